// File: rtl/cfg_serial_sched.sv
// Round-robin scheduler that gives four serial devices turns on one shared sdo/sclk bus, with a per-device select and latch strobe.
// Latency: a req seen in IDLE (cycle 0) gives LOAD at cycle 1, the first bit at cycle 2, and strobe/ack at cycle 2+2*LEN_g.
// Backpressure: req is a level held until ack. While busy, req and data are ignored. The payload is captured on entry to LOAD.
//
// Ports: clk_1M (sole clock), clr (synchronous active-high reset), req[3:0] (level requests),
//        data0..data3 (right-justified payloads, bit LENk-1 sent first), ack[3:0] (one-cycle done pulse),
//        busy (not IDLE), sdo/sclk (shared serial bus, sampled on sclk rise),
//        sel_n[3:0] (active-low select during LOAD/SHIFT), strb[3:0] (one-cycle latch pulse after last bit).
// Build option: define CFG_SCHED_FIXED_PRIO_EN for fixed priority (req[0] highest), with no round-robin pointer.
`timescale 1ns/1ps
module cfg_serial_sched #(
    parameter int LEN0 = 32,
    parameter int LEN1 = 8,
    parameter int LEN2 = 8,
    parameter int LEN3 = 8
) (
    input  logic        clk_1M,
    input  logic        clr,
    input  logic [3:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [31:0] data3,
    output logic [3:0]  ack,
    output logic        busy,
    output logic        sdo,
    output logic        sclk,
    output logic [3:0]  sel_n,
    output logic [3:0]  strb
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        STROBE   = 3'd4,
        GAP      = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  gnt;
    logic [31:0] shreg;
    logic [5:0]  cnt;

    logic        any_req;
    logic [1:0]  pick;
    logic [5:0]  pick_len;
    logic [31:0] pick_data;
    logic [31:0] pick_aligned;

    assign any_req = |req;

`ifdef CFG_SCHED_FIXED_PRIO_EN
    // Lowest index wins. The loop runs downward so the final assignment is the highest-priority request.
    always_comb begin
        pick = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                pick = 2'(i);
            end
        end
    end
`else
    logic [1:0] rr_ptr;

    // The search starts at the pointer and wraps 3->0. The first request found wins.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        pick  = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end
`endif

    // Select the payload and length of the winning requester.
    always_comb begin
        pick_len  = 6'(LEN0);
        pick_data = data0;
        case (pick)
            2'd0: begin pick_len = 6'(LEN0); pick_data = data0; end
            2'd1: begin pick_len = 6'(LEN1); pick_data = data1; end
            2'd2: begin pick_len = 6'(LEN2); pick_data = data2; end
            default: begin pick_len = 6'(LEN3); pick_data = data3; end
        endcase
    end

    // Left-align the payload so that bit LEN-1 lands in bit 31, which drives sdo.
    assign pick_aligned = pick_data << (6'd32 - pick_len);

    always_ff @(posedge clk_1M) begin
        if (clr) begin
            state <= IDLE;
            gnt   <= 2'd0;
            shreg <= 32'd0;
            cnt   <= 6'd0;
`ifndef CFG_SCHED_FIXED_PRIO_EN
            rr_ptr <= 2'd0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        // The payload is captured here, while still idle.
                        // Later changes to data therefore cannot reach the wire.
                        gnt   <= pick;
                        shreg <= pick_aligned;
                        cnt   <= pick_len;
`ifndef CFG_SCHED_FIXED_PRIO_EN
                        rr_ptr <= pick + 2'd1;
`endif
                    end
                end
                SHIFT_HI: begin
                    if (cnt != 6'd1) begin
                        shreg <= {shreg[30:0], 1'b0};
                        cnt   <= cnt - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        sdo       = 1'b0;
        sclk      = 1'b0;
        sel_n     = 4'b1111;
        strb      = 4'b0000;
        ack       = 4'b0000;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                sel_n     = ~(4'b0001 << gnt);
                state_nxt = SHIFT_LO;
            end
            SHIFT_LO: begin
                sel_n     = ~(4'b0001 << gnt);
                sdo       = shreg[31];
                state_nxt = SHIFT_HI;
            end
            SHIFT_HI: begin
                sel_n     = ~(4'b0001 << gnt);
                sdo       = shreg[31];
                sclk      = 1'b1;
                state_nxt = (cnt == 6'd1) ? STROBE : SHIFT_LO;
            end
            STROBE: begin
                strb      = 4'b0001 << gnt;
                ack       = 4'b0001 << gnt;
                state_nxt = GAP;
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cfg_serial_sched.sv
`timescale 1ns/1ps
module tb_cfg_serial_sched;

    logic        clk;
    logic        clr;
    logic [3:0]  req;
    logic [31:0] data_r [4];
    logic [3:0]  ack;
    logic        busy;
    logic        sdo;
    logic        sclk;
    logic [3:0]  sel_n;
    logic [3:0]  strb;

    int checks = 0;
    int errors = 0;

    cfg_serial_sched #(
        .LEN0(32), .LEN1(8), .LEN2(8), .LEN3(8)
    ) dut (
        .clk_1M(clk),
        .clr   (clr),
        .req   (req),
        .data0 (data_r[0]),
        .data1 (data_r[1]),
        .data2 (data_r[2]),
        .data3 (data_r[3]),
        .ack   (ack),
        .busy  (busy),
        .sdo   (sdo),
        .sclk  (sclk),
        .sel_n (sel_n),
        .strb  (strb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          g;
        int          len;
        logic [31:0] data;
        logic [31:0] exp_word;
        int          exp_ack;
        bit          mutate;
    } vec_t;

    // One request from idle. Outputs are sampled once per cycle at the falling edge.
    task automatic run_xfer(input int idx, input vec_t v);
        logic [31:0] word;
        int nbits, ack_cyc, selbad, sdobad, ackbad, end_cyc;
        logic prev_sclk;
        logic [3:0] exp_sel;
        word = 32'd0; nbits = 0; ack_cyc = -1; selbad = 0; sdobad = 0; ackbad = 0;
        end_cyc = -1; prev_sclk = 1'b0;
        data_r[v.g] = v.data;
        req = 4'b0001 << v.g;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (v.mutate && cyc == 2) begin
                data_r[v.g] = 32'd0;
                req = 4'b0000;
            end
            exp_sel = (cyc <= 1 + 2 * v.len) ? ~(4'b0001 << v.g) : 4'b1111;
            if (sel_n !== exp_sel) selbad++;
            if ((cyc < 2 || cyc > 1 + 2 * v.len) && sdo !== 1'b0) sdobad++;
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                word = {word[30:0], sdo};
                nbits++;
            end
            prev_sclk = sclk;
            if (ack !== 4'b0000) begin
                if (ack_cyc < 0) ack_cyc = cyc; else ackbad++;
                if (ack !== (4'b0001 << v.g) || strb !== ack || sclk !== 1'b0) ackbad++;
                req[v.g] = 1'b0;
            end else if (strb !== 4'b0000) begin
                ackbad++;
            end
            if (busy === 1'b0) begin
                end_cyc = cyc;
                break;
            end
        end
        check($sformatf("v%0d_word", idx), word, v.exp_word);
        check($sformatf("v%0d_nbits", idx), nbits, v.len);
        check($sformatf("v%0d_ack_cycle", idx), ack_cyc, v.exp_ack);
        check($sformatf("v%0d_sel_n_bad", idx), selbad, 0);
        check($sformatf("v%0d_sdo_idle_bad", idx), sdobad, 0);
        check($sformatf("v%0d_ack_strb_bad", idx), ackbad, 0);
        check($sformatf("v%0d_idle_cycle", idx), end_cyc, v.exp_ack + 2);
    endtask

    vec_t vecs [6];
    int   exp_ord [5];

    initial begin
        int rises, clr_cyc, late_bad, k, pending, first_zero, ohbad, g;
        int grants [5];

        vecs[0] = '{g: 1, len: 8,  data: 32'h000000A5, exp_word: 32'h000000A5, exp_ack: 18, mutate: 1'b0};
        vecs[1] = '{g: 0, len: 32, data: 32'h12345678, exp_word: 32'h12345678, exp_ack: 66, mutate: 1'b0};
        vecs[2] = '{g: 2, len: 8,  data: 32'hFFFFFF3C, exp_word: 32'h0000003C, exp_ack: 18, mutate: 1'b0};
        vecs[3] = '{g: 3, len: 8,  data: 32'h00000081, exp_word: 32'h00000081, exp_ack: 18, mutate: 1'b0};
        vecs[4] = '{g: 1, len: 8,  data: 32'h5A5A5A5A, exp_word: 32'h0000005A, exp_ack: 18, mutate: 1'b0};
        vecs[5] = '{g: 3, len: 8,  data: 32'h0000003F, exp_word: 32'h0000003F, exp_ack: 18, mutate: 1'b1};
`ifdef CFG_SCHED_FIXED_PRIO_EN
        exp_ord = '{0, 0, 1, 2, 3};
`else
        exp_ord = '{0, 1, 2, 3, 0};
`endif

        clr = 1'b1;
        req = 4'b0000;
        for (int i = 0; i < 4; i++) data_r[i] = 32'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_sclk", sclk, 0);
        check("rst_sdo", sdo, 0);
        check("rst_sel_n", sel_n, 4'b1111);
        check("rst_strb", strb, 4'b0000);
        check("rst_ack", ack, 4'b0000);
        clr = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        for (int i = 0; i < 6; i++) begin
            run_xfer(i, vecs[i]);
        end

        // Abort with clr on the 4th sclk-high cycle of a requester-2 transfer
        data_r[2] = 32'h000000C3;
        req = 4'b0100;
        rises = 0; clr_cyc = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (sclk === 1'b1) rises++;
            if (rises == 4) begin
                clr_cyc = cyc;
                clr = 1'b1;
                break;
            end
        end
        check("abort_clr_cycle", clr_cyc, 9);
        @(negedge clk);
        clr = 1'b0;
        req = 4'b0000;
        check("abort_busy", busy, 0);
        check("abort_sel_n", sel_n, 4'b1111);
        check("abort_sclk_sdo", {sclk, sdo}, 2'b00);
        late_bad = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (ack[2] !== 1'b0 || strb[2] !== 1'b0 || busy !== 1'b0) late_bad++;
        end
        check("abort_no_ack", late_bad, 0);

        // Arbitration order. The pointer was cleared by the abort above.
        req = 4'b1111;
        k = 0; pending = 0; first_zero = 1; ohbad = 0;
        for (int cyc = 0; cyc < 600 && k < 5; cyc++) begin
            @(negedge clk);
            if (!$onehot0(ack) || !$onehot0(strb) || !$onehot0(~sel_n)) ohbad++;
            if (pending != 0) begin
                req[0] = 1'b1;
                pending = 0;
            end
            if (ack !== 4'b0000) begin
                g = 0;
                for (int b = 0; b < 4; b++) if (ack[b] === 1'b1) g = b;
                grants[k] = g;
                k++;
                req[g] = 1'b0;
                if (g == 0 && first_zero != 0) begin
                    first_zero = 0;
                    pending = 1;
                end
            end
        end
        check("arb_grant_count", k, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < k) check($sformatf("arb_grant%0d", i), grants[i], exp_ord[i]);
        end
        check("arb_onehot_bad", ohbad, 0);
        req = 4'b0000;
        for (int cyc = 0; cyc < 80 && busy !== 1'b0; cyc++) @(negedge clk);
        check("arb_final_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
